// File: rtl/jala_ctrl_pkg.sv
// Shared types for the JALA multicycle control unit: FSM states, opcodes,
// memory address/data select encodings and the decoded control bundle.
package jala_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_JPOP = 4'h1;
  localparam logic [3:0] OP_BR   = 4'h2;
  localparam logic [3:0] OP_LDV  = 4'h3;
  localparam logic [3:0] OP_RPSH = 4'h4;
  localparam logic [3:0] OP_RPOP = 4'h5;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Port 1 / port 2 address sources: 00 PC/MSP, 01 MSP/RSP, 10 ValA
  localparam logic [1:0] DST_BASE  = 2'b00;
  localparam logic [1:0] DST_STACK = 2'b01;
  localparam logic [1:0] DST_VALA  = 2'b10;

  typedef enum logic [2:0] {
    MD_VALA = 3'b000,
    MD_VALB = 3'b001,
    MD_PC   = 3'b010,
    MD_RES  = 3'b011,
    MD_ZEXT = 3'b100
  } mem_data_e;

  typedef struct packed {
    logic      pc_write;
    logic      pc_source;
    logic      pc_add;
    logic      msp_write;
    logic      msp_pop;
    logic      rsp_write;
    logic      rsp_pop;
    logic      ir_write;
    logic      vala_write;
    logic      valb_write;
    logic      mem_read1;
    logic      mem_read2;
    logic      mem_write1;
    logic      mem_write2;
    logic [1:0] mem_dst1;
    logic [1:0] mem_dst2;
    mem_data_e mem_data;
  } ctrl_t;

endpackage

// File: rtl/jala_ctrl_decode.sv
// Combinational {state, opcode} -> control bundle decoder for the JALA FSM.
// JALA_ILLEGAL_TRAP_EN: illegal opcodes issue no strobes in EXEC (trap path).
module jala_ctrl_decode
  import jala_ctrl_pkg::*;
(
  input  state_e     state,
  input  logic [3:0] op,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.pc_write  = 1'b1;
        ctrl.mem_read1 = 1'b1;
        ctrl.mem_read2 = 1'b1;
        ctrl.mem_dst1  = DST_BASE;
        ctrl.mem_dst2  = DST_BASE;
        ctrl.msp_write = 1'b1;
        ctrl.msp_pop   = 1'b1;
      end
      ST_DECODE: begin
        ctrl.ir_write   = 1'b1;
        ctrl.vala_write = 1'b1;
      end
      ST_EXEC: begin
        case (op)
          OP_NOP:  ctrl.msp_write = 1'b1;
          OP_JPOP: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = 1'b1;
          end
          OP_BR: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_add    = 1'b1;
            ctrl.msp_write = 1'b1;
          end
          OP_LDV: begin
            ctrl.mem_read1 = 1'b1;
            ctrl.mem_dst1  = DST_VALA;
            ctrl.msp_write = 1'b1;
          end
          OP_RPSH: begin
            ctrl.mem_write2 = 1'b1;
            ctrl.mem_dst2   = DST_STACK;
            ctrl.mem_data   = MD_VALA;
            ctrl.rsp_write  = 1'b1;
          end
          OP_RPOP: begin
            ctrl.mem_read2 = 1'b1;
            ctrl.mem_dst2  = DST_STACK;
            ctrl.rsp_write = 1'b1;
            ctrl.rsp_pop   = 1'b1;
            ctrl.msp_write = 1'b1;
          end
          OP_HALT: ;
          default: begin
`ifdef JALA_ILLEGAL_TRAP_EN
            ctrl.msp_write = 1'b0;
`else
            ctrl.msp_write = 1'b1;
`endif
          end
        endcase
      end
      ST_WB: begin
        ctrl.valb_write = (op == OP_LDV);
        ctrl.vala_write = (op == OP_RPOP);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/jala_control_fsm.sv
// Multicycle control FSM for the 16-bit JALA stack datapath.
// Optional JALA_ILLEGAL_TRAP_EN: illegal opcodes enter an absorbing TRAP state and raise Fault.
module jala_control_fsm
  import jala_ctrl_pkg::*;
#(
  parameter int INIT_CYCLES = 5
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        Stall,
  input  logic [15:0] IROut,
  output logic        PCWrite,
  output logic        PCSource,
  output logic        PCAdd,
  output logic        MSPWrite,
  output logic        MSPop,
  output logic        RSPWrite,
  output logic        RSPop,
  output logic        IRWrite,
  output logic        ValAWrite,
  output logic        ValBWrite,
  output logic        MemRead1,
  output logic        MemRead2,
  output logic        MemWrite1,
  output logic        MemWrite2,
  output logic [1:0]  MemDst1,
  output logic [1:0]  MemDst2,
  output logic [2:0]  MemData,
  output logic        Halted,
  output logic        Fault,
  output logic [2:0]  State
);

  localparam int CW = $clog2(INIT_CYCLES + 2);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    op_q, op_d;
  logic          halted_q, halted_d;
  logic          fault_q, fault_d;
  logic [3:0]    op_sel;
  ctrl_t         ctrl, ctrl_g;
  logic          unused_ir;

  assign unused_ir = ^IROut[11:0];

  // WB needs the opcode seen in EXEC, so it is held locally rather than re-read from IR
  assign op_sel = (state_q == ST_WB) ? op_q : IROut[15:12];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    if (!Stall) begin
      case (state_q)
        ST_INIT: begin
          if (int'(cnt_q) + 1 >= INIT_CYCLES) state_d = ST_FETCH;
          else                                cnt_d   = cnt_q + CW'(1);
        end
        ST_FETCH:  state_d = ST_DECODE;
        ST_DECODE: state_d = ST_EXEC;
        ST_EXEC: begin
          op_d = IROut[15:12];
          case (IROut[15:12])
            OP_NOP, OP_JPOP, OP_BR, OP_RPSH: state_d = ST_FETCH;
            OP_LDV, OP_RPOP:                 state_d = ST_WB;
            OP_HALT:                         state_d = ST_HALT;
            default: begin
`ifdef JALA_ILLEGAL_TRAP_EN
              state_d = ST_TRAP;
`else
              state_d = ST_FETCH;
`endif
            end
          endcase
        end
        ST_WB:   state_d = ST_FETCH;
        ST_HALT: state_d = ST_HALT;
        ST_TRAP: state_d = ST_TRAP;
        default: state_d = ST_INIT;
      endcase
    end
    halted_d = halted_q | (state_d == ST_HALT);
`ifdef JALA_ILLEGAL_TRAP_EN
    fault_d  = fault_q | (state_d == ST_TRAP);
`else
    fault_d  = 1'b0;
`endif
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q  <= ST_INIT;
      cnt_q    <= '0;
      op_q     <= '0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
    end
  end

  jala_ctrl_decode u_decode (
    .state (state_q),
    .op    (op_sel),
    .ctrl  (ctrl)
  );

  // A stall drops every strobe but leaves the selects at their state value
  always_comb begin
    ctrl_g = ctrl;
    if (Stall) begin
      ctrl_g.pc_write   = 1'b0;
      ctrl_g.msp_write  = 1'b0;
      ctrl_g.rsp_write  = 1'b0;
      ctrl_g.ir_write   = 1'b0;
      ctrl_g.vala_write = 1'b0;
      ctrl_g.valb_write = 1'b0;
      ctrl_g.mem_read1  = 1'b0;
      ctrl_g.mem_read2  = 1'b0;
      ctrl_g.mem_write1 = 1'b0;
      ctrl_g.mem_write2 = 1'b0;
    end
  end

  assign PCWrite   = ctrl_g.pc_write;
  assign PCSource  = ctrl_g.pc_source;
  assign PCAdd     = ctrl_g.pc_add;
  assign MSPWrite  = ctrl_g.msp_write;
  assign MSPop     = ctrl_g.msp_pop;
  assign RSPWrite  = ctrl_g.rsp_write;
  assign RSPop     = ctrl_g.rsp_pop;
  assign IRWrite   = ctrl_g.ir_write;
  assign ValAWrite = ctrl_g.vala_write;
  assign ValBWrite = ctrl_g.valb_write;
  assign MemRead1  = ctrl_g.mem_read1;
  assign MemRead2  = ctrl_g.mem_read2;
  assign MemWrite1 = ctrl_g.mem_write1;
  assign MemWrite2 = ctrl_g.mem_write2;
  assign MemDst1   = ctrl_g.mem_dst1;
  assign MemDst2   = ctrl_g.mem_dst2;
  assign MemData   = ctrl_g.mem_data;
  assign Halted    = halted_q;
  assign Fault     = fault_q;
  assign State     = state_q;

endmodule

// File: tb/tb_jala_control_fsm.sv
// Directed bench for jala_control_fsm: init timing, per-opcode sequences, stall, halt, reset.
// Build with +define+JALA_ILLEGAL_TRAP_EN to exercise the trap variant.
module tb_jala_control_fsm;
  import jala_ctrl_pkg::*;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        Stall;
  logic [15:0] IROut;
  logic PCWrite, PCSource, PCAdd, MSPWrite, MSPop, RSPWrite, RSPop;
  logic IRWrite, ValAWrite, ValBWrite, MemRead1, MemRead2, MemWrite1, MemWrite2;
  logic [1:0] MemDst1, MemDst2;
  logic [2:0] MemData;
  logic Halted, Fault;
  logic [2:0] State;

  int n_checks = 0;
  int n_errors = 0;

  jala_control_fsm dut (
    .CLK(CLK), .RSTn(RSTn), .Stall(Stall), .IROut(IROut),
    .PCWrite(PCWrite), .PCSource(PCSource), .PCAdd(PCAdd),
    .MSPWrite(MSPWrite), .MSPop(MSPop), .RSPWrite(RSPWrite), .RSPop(RSPop),
    .IRWrite(IRWrite), .ValAWrite(ValAWrite), .ValBWrite(ValBWrite),
    .MemRead1(MemRead1), .MemRead2(MemRead2), .MemWrite1(MemWrite1), .MemWrite2(MemWrite2),
    .MemDst1(MemDst1), .MemDst2(MemDst2), .MemData(MemData),
    .Halted(Halted), .Fault(Fault), .State(State)
  );

  always #5 CLK = ~CLK;

  // Packed view: PCW PCS PCA MSPW MSPop RSPW RSPop IRW VAW VBW MR1 MR2 MW1 MW2 | MemDst1 | MemDst2 | MemData
  logic [20:0] obs;
  assign obs = {PCWrite, PCSource, PCAdd, MSPWrite, MSPop, RSPWrite, RSPop,
                IRWrite, ValAWrite, ValBWrite, MemRead1, MemRead2, MemWrite1, MemWrite2,
                MemDst1, MemDst2, MemData};

  localparam logic [20:0] V_ZERO       = 21'b00000000000000_00_00_000;
  localparam logic [20:0] V_FETCH      = 21'b10011000001100_00_00_000;
  localparam logic [20:0] V_FETCH_STL  = 21'b00001000000000_00_00_000;
  localparam logic [20:0] V_DECODE     = 21'b00000001100000_00_00_000;
  localparam logic [20:0] V_NOP_EX     = 21'b00010000000000_00_00_000;
  localparam logic [20:0] V_JPOP_EX    = 21'b11000000000000_00_00_000;
  localparam logic [20:0] V_BR_EX      = 21'b10110000000000_00_00_000;
  localparam logic [20:0] V_LDV_EX     = 21'b00010000001000_10_00_000;
  localparam logic [20:0] V_LDV_WB     = 21'b00000000010000_00_00_000;
  localparam logic [20:0] V_RPSH_EX    = 21'b00000100000001_00_01_000;
  localparam logic [20:0] V_RPOP_EX    = 21'b00010110000100_00_01_000;
  localparam logic [20:0] V_RPOP_STL   = 21'b00000010000000_00_01_000;
  localparam logic [20:0] V_RPOP_WB    = 21'b00000000100000_00_00_000;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_cycle(input string tag, input state_e st, input logic [20:0] v);
    chk_eq({tag, "_state"}, 32'(State), 32'(st));
    chk_eq({tag, "_outs"}, 32'(obs), 32'(v));
  endtask

  // Enter at a sampled FETCH cycle, leave at the next FETCH cycle
  task automatic run_instr(input logic [15:0] ir, input logic [20:0] v_ex,
                           input bit has_wb, input logic [20:0] v_wb);
    IROut = ir;
    check_cycle($sformatf("i%h_fetch", ir), ST_FETCH, V_FETCH);
    step();
    check_cycle($sformatf("i%h_decode", ir), ST_DECODE, V_DECODE);
    step();
    check_cycle($sformatf("i%h_exec", ir), ST_EXEC, v_ex);
    if (has_wb) begin
      step();
      check_cycle($sformatf("i%h_wb", ir), ST_WB, v_wb);
    end
    step();
  endtask

  // Assert reset asynchronously, release, walk INIT; returns at the first FETCH cycle
  task automatic do_reset();
    RSTn = 1'b0;
    #1;
    check_cycle("rst", ST_INIT, V_ZERO);
    chk_eq("rst_halted", 32'(Halted), 32'd0);
    chk_eq("rst_fault", 32'(Fault), 32'd0);
    step();
    step();
    RSTn = 1'b1;
    check_cycle("init1", ST_INIT, V_ZERO);
    for (int i = 2; i <= 5; i++) begin
      step();
      check_cycle($sformatf("init%0d", i), ST_INIT, V_ZERO);
    end
    step();
  endtask

  initial begin
    RSTn  = 1'b0;
    Stall = 1'b0;
    IROut = 16'h0000;
    step();
    do_reset();

    run_instr(16'h0000, V_NOP_EX, 1'b0, V_ZERO);
    run_instr(16'h0000, V_NOP_EX, 1'b0, V_ZERO);
    run_instr(16'h1000, V_JPOP_EX, 1'b0, V_ZERO);
    run_instr(16'h2005, V_BR_EX, 1'b0, V_ZERO);
    run_instr(16'h3000, V_LDV_EX, 1'b1, V_LDV_WB);
    run_instr(16'h4000, V_RPSH_EX, 1'b0, V_ZERO);
    run_instr(16'h5000, V_RPOP_EX, 1'b1, V_RPOP_WB);

    // Stall in FETCH and for three cycles in DECODE
    IROut = 16'h0000;
    Stall = 1'b1;
    #1;
    check_cycle("stl_fetch", ST_FETCH, V_FETCH_STL);
    Stall = 1'b0;
    #1;
    check_cycle("stl_fetch_rel", ST_FETCH, V_FETCH);
    step();
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_cycle($sformatf("stl_dec%0d", i), ST_DECODE, V_ZERO);
      if (i < 2) step();
    end
    Stall = 1'b0;
    #1;
    check_cycle("stl_dec_rel", ST_DECODE, V_DECODE);
    step();
    check_cycle("stl_dec_exec", ST_EXEC, V_NOP_EX);
    step();

    // Stall in RPOP EXEC keeps selects and the WB still follows
    IROut = 16'h5000;
    check_cycle("stl_rpop_fetch", ST_FETCH, V_FETCH);
    step();
    step();
    Stall = 1'b1;
    #1;
    check_cycle("stl_rpop_ex0", ST_EXEC, V_RPOP_STL);
    step();
    check_cycle("stl_rpop_ex1", ST_EXEC, V_RPOP_STL);
    Stall = 1'b0;
    #1;
    check_cycle("stl_rpop_rel", ST_EXEC, V_RPOP_EX);
    step();
    check_cycle("stl_rpop_wb", ST_WB, V_RPOP_WB);
    step();

    // Reset in the middle of EXEC
    IROut = 16'h2000;
    check_cycle("mid_fetch", ST_FETCH, V_FETCH);
    step();
    step();
    check_cycle("mid_exec", ST_EXEC, V_BR_EX);
    do_reset();

    // HALT is absorbing and ignores stall
    IROut = 16'hF000;
    check_cycle("halt_fetch", ST_FETCH, V_FETCH);
    step();
    step();
    check_cycle("halt_exec", ST_EXEC, V_ZERO);
    chk_eq("halt_exec_flag", 32'(Halted), 32'd0);
    step();
    check_cycle("halt_enter", ST_HALT, V_ZERO);
    chk_eq("halt_flag", 32'(Halted), 32'd1);
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_eq($sformatf("halt_stl%0d_state", i), 32'(State), 32'(ST_HALT));
      chk_eq($sformatf("halt_stl%0d_flag", i), 32'(Halted), 32'd1);
    end
    Stall = 1'b0;
    step();
    check_cycle("halt_hold", ST_HALT, V_ZERO);
    chk_eq("halt_hold_flag", 32'(Halted), 32'd1);

    do_reset();
    chk_eq("post_halt_rst_flag", 32'(Halted), 32'd0);

    // Illegal opcode
`ifdef JALA_ILLEGAL_TRAP_EN
    IROut = 16'h7000;
    check_cycle("ill_fetch", ST_FETCH, V_FETCH);
    step();
    step();
    check_cycle("ill_exec", ST_EXEC, V_ZERO);
    step();
    check_cycle("ill_trap", ST_TRAP, V_ZERO);
    chk_eq("ill_fault", 32'(Fault), 32'd1);
    step();
    check_cycle("ill_trap_hold", ST_TRAP, V_ZERO);
    chk_eq("ill_fault_hold", 32'(Fault), 32'd1);
`else
    run_instr(16'h7000, V_NOP_EX, 1'b0, V_ZERO);
    chk_eq("ill_fault", 32'(Fault), 32'd0);
    run_instr(16'hE123, V_NOP_EX, 1'b0, V_ZERO);
    chk_eq("ill_back_fetch", 32'(State), 32'(ST_FETCH));
    chk_eq("ill_fault_end", 32'(Fault), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
